piso_8bit: RTL and testbench

Parallel-in/serial-out transmitter for the 8-bit register datapath. It captures a parallel byte on a load handshake and shifts it out one bit per clock with a bit-valid strobe and an end-of-frame pulse. It is the sending end of the serial link whose receiving end deserialises into an 8-bit register. It sits between the register bank's `Q` output and the serial line.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_counter.sv | 44 ++++
 rtl/piso_8bit.sv | 131 +++++++++++++
 tb/tb_piso_8bit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_8bit serial transmitter.
package piso_pkg;

  // Frame states. PARITY is only reachable when PISO_PARITY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int unsigned PISO_WIDTH_DEFAULT = 8;

  // Bit-counter width, sized so the counter can hold WIDTH, the last frame
  // index when a parity bit is appended.
  function automatic int unsigned piso_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear on load, saturating increment,
// terminal-count flag at TERM (the last frame bit index).
module piso_bit_counter #(
  parameter int unsigned CW   = 4,
  parameter int unsigned TERM = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] TERM_C = CW'(TERM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; hold at TERM so it never wraps.
  // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TERM_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TERM_C);

endmodule : piso_bit_counter

// File: rtl/piso_8bit.sv
// Parallel-in/serial-out transmitter. Captures Din on load && ready and
// shifts it out one bit per clock with sout_valid, pulsing done on the last
// frame bit. Define PISO_PARITY_EN to append an even-parity bit (FRAME =
// WIDTH+1); by default FRAME = WIDTH with no parity logic.
module piso_8bit
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned   CW        = piso_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             head;
  logic             accept;
  logic             last_data;

  assign head      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign accept    = (state_q == ST_IDLE) && load;
  assign last_data = (cnt == LAST_DATA);

  piso_bit_counter #(
    .CW   (CW),
    .TERM (FRAME - 1)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .inc_i (state_q != ST_IDLE),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  // Shift register next value: capture on an accepted load, move toward the head while shifting.
  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = Din;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Frame state machine and shift register; reset beats load and aborts any frame in flight.
  // NOTE: the shift register is reset too, so sout starts from a known value after every reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      unique case (state_q)
        ST_IDLE: begin
          if (load) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
`ifdef PISO_PARITY_EN
          if (last_data) state_q <= ST_PARITY;
`else
          if (last_data) state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  logic par_q;

  // Even-parity accumulator: XOR of every data bit as it leaves the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      par_q <= par_q ^ head;
    end
  end
`endif

  // Outputs decoded from registered state only; nothing here depends on Din or load.
  always_comb begin
    ready      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SHIFT: begin
        sout_valid = 1'b1;
        sout       = head;
        done       = tc;
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sout_valid = 1'b1;
        sout       = par_q;
        done       = tc;
      end
`endif
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule : piso_8bit

// File: tb/tb_piso_8bit.sv
// Bench for piso_8bit: one MSB-first and one LSB-first instance sharing the
// clock and reset. Expected frame bits go into a scoreboard queue when a load
// is driven and are popped as the DUT shifts them out.
module tb_piso_8bit;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  typedef struct {
    logic sout;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_m = 8'h00;
  logic [7:0] din_l = 8'h00;
  logic       load_m = 1'b0;
  logic       load_l = 1'b0;
  logic       ready_m, sout_m, valid_m, done_m;
  logic       ready_l, sout_l, valid_l, done_l;
  logic       sel_lsb = 1'b0;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  piso_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .Din        (din_m),
    .load       (load_m),
    .ready      (ready_m),
    .sout       (sout_m),
    .sout_valid (valid_m),
    .done       (done_m)
  );

  piso_8bit #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .Din        (din_l),
    .load       (load_l),
    .ready      (ready_l),
    .sout       (sout_l),
    .sout_valid (valid_l),
    .done       (done_l)
  );

  always #5 clk = ~clk;

  wire o_ready = sel_lsb ? ready_l : ready_m;
  wire o_sout  = sel_lsb ? sout_l  : sout_m;
  wire o_valid = sel_lsb ? valid_l : valid_m;
  wire o_done  = sel_lsb ? done_l  : done_m;

  task automatic check(input string tag, input logic observed, input logic expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic drive_load(input logic v, input logic [7:0] d);
    if (sel_lsb) begin
      load_l = v;
      din_l  = d;
    end else begin
      load_m = v;
      din_m  = d;
    end
  endtask

  // Call at a negedge with the selected DUT idle. inj_at: frame bit index at
  // which a one-edge load of 8'h04 is attempted (-1 none). abort_at: bit
  // index after which reset is asserted (-1 none).
  task automatic run_frame(input logic lsb, input logic [7:0] data,
                           input int inj_at, input int abort_at);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.sout = lsb ? data[k] : data[7-k];
      e.done = (k == FRAME - 1);
      sb.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.sout = ^data;
    e.done = 1'b1;
    sb.push_back(e);
`endif
    sel_lsb = lsb;
    drive_load(1'b1, data);
    @(posedge clk);
    #1;
    drive_load(1'b0, ~data);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("bit%0d_valid", i), o_valid, 1'b1);
      check($sformatf("bit%0d_sout", i), o_sout, e.sout);
      check($sformatf("bit%0d_done", i), o_done, e.done);
      check($sformatf("bit%0d_ready", i), o_ready, 1'b0);
      if (i == inj_at) drive_load(1'b1, 8'h04);
      else drive_load(1'b0, ~data);
      if (i == abort_at) begin
        reset = 1'b1;
        break;
      end
    end
    drive_load(1'b0, 8'h00);
    if (abort_at >= 0) begin
      @(negedge clk);
      check("abort_valid", o_valid, 1'b0);
      check("abort_ready", o_ready, 1'b1);
      check("abort_done", o_done, 1'b0);
      sb.delete();
      reset = 1'b0;
    end
    @(negedge clk);
    check("idle_ready", o_ready, 1'b1);
    check("idle_valid", o_valid, 1'b0);
    check("idle_done", o_done, 1'b0);
    check("idle_sout", o_sout, 1'b0);
  endtask

  initial begin
    // Reset held for 3 edges with load asserted and Din all ones.
    reset  = 1'b1;
    load_m = 1'b1;
    load_l = 1'b1;
    din_m  = 8'hFF;
    din_l  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready_m", ready_m, 1'b1);
      check("rst_valid_m", valid_m, 1'b0);
      check("rst_done_m", done_m, 1'b0);
      check("rst_sout_m", sout_m, 1'b0);
      check("rst_ready_l", ready_l, 1'b1);
      check("rst_valid_l", valid_l, 1'b0);
    end
    reset  = 1'b0;
    load_m = 1'b0;
    load_l = 1'b0;
    @(negedge clk);
    check("post_rst_valid_m", valid_m, 1'b0);
    check("post_rst_ready_m", ready_m, 1'b1);

    // MSB-first frame.
    run_frame(1'b0, 8'hA5, -1, -1);
    // Back-to-back reload on the first idle cycle.
    run_frame(1'b0, 8'h3C, -1, -1);
    // LSB-first frames.
    run_frame(1'b1, 8'h01, -1, -1);
    run_frame(1'b1, 8'hC6, -1, -1);
    // Load attempted at bit 3 must be ignored.
    run_frame(1'b0, 8'h03, 3, -1);
    @(negedge clk);
    check("no_second_frame_valid", valid_m, 1'b0);
    check("no_second_frame_ready", ready_m, 1'b1);
    // Reset mid-frame at bit 4.
    run_frame(1'b0, 8'hA2, -1, 4);
    // Full frame after an abort, and the parity example word.
    run_frame(1'b0, 8'hA2, -1, -1);
    run_frame(1'b1, 8'hFF, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_piso_8bit
